// File: rtl/above_nbr_ctrl.sv
// Above-neighbour controller: one pixels_buf read per 8x2 block, edge padding and
// first-line substitution, registered neighbour sets with a fixed 6-cycle latency.
module above_nbr_ctrl #(
    parameter int unsigned MAX_SLICE_WIDTH = 2560,
    parameter int unsigned RD_LATENCY      = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 flush,
    input  logic                                 sos,
    input  logic [$clog2(MAX_SLICE_WIDTH)-1:0]   slice_width,
    input  logic [12:0]                          midPoint,
    input  logic                                 nb_req,
    output logic                                 nb_busy,
    output logic                                 nb_valid,
    output logic                                 nb_err,
    output logic                                 above_avail,
    output logic                                 left_edge,
    output logic                                 right_edge,
    output logic                                 decoding_proc_rd_req,
    input  logic [16*3*14-1:0]                   pixelsAboveForTrans_in,
    input  logic [8*3*14-1:0]                    pixelsAboveForMpp_in,
    input  logic                                 decoding_proc_rd_valid,
    output logic [16*3*14-1:0]                   pixelsAboveForTrans_p,
    output logic [8*3*14-1:0]                    pixelsAboveForMpp_p
);

    localparam int unsigned SwW  = $clog2(MAX_SLICE_WIDTH);
    localparam int unsigned BlkW = SwW - 3;
    localparam int unsigned CntW = $clog2(RD_LATENCY + 1);
    localparam int unsigned TransW = 16 * 3 * 14;
    localparam int unsigned MppW   = 8 * 3 * 14;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StLoad} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [BlkW-1:0]     blk_x_q, blk_x_d;
    logic                first_line_q, first_line_d;
    logic                err_q, err_d;
    logic                valid_q, valid_d;
    logic                avail_q, avail_d;
    logic                left_q, left_d;
    logic                right_q, right_d;
    logic [TransW-1:0]   trans_q, trans_d;
    logic [MppW-1:0]     mpp_q, mpp_d;

    logic [BlkW-1:0]     nblk, last_blk;
    logic                cur_left, cur_right, expiry;
    logic [13:0]         mid_ext;
    logic [TransW-1:0]   pad_trans;
    logic [MppW-1:0]     pad_mpp;

    assign nblk      = slice_width[SwW-1:3];
    assign last_blk  = nblk - BlkW'(1);
    assign cur_left  = (blk_x_q == '0);
    assign cur_right = (blk_x_q == last_blk);
    assign expiry    = (state_q == StWait) && (cnt_q == CntW'(1));
    assign mid_ext   = {midPoint[12], midPoint};

    // Padding acts on the raw window during the capture cycle so the register holds final data.
    always_comb begin
        pad_trans = pixelsAboveForTrans_in;
        pad_mpp   = pixelsAboveForMpp_in;
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 16; k++) begin
                if (first_line_q) begin
                    pad_trans[(16*c+k)*14 +: 14] = mid_ext;
                end else if (cur_left && k < 4) begin
                    pad_trans[(16*c+k)*14 +: 14] = pixelsAboveForTrans_in[(16*c+4)*14 +: 14];
                end else if (cur_right && k > 11) begin
                    pad_trans[(16*c+k)*14 +: 14] = pixelsAboveForTrans_in[(16*c+11)*14 +: 14];
                end
            end
            for (int k = 0; k < 8; k++) begin
                if (first_line_q) begin
                    pad_mpp[(8*c+k)*14 +: 14] = mid_ext;
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        blk_x_d      = blk_x_q;
        first_line_d = first_line_q;
        err_d        = err_q;
        valid_d      = 1'b0;
        avail_d      = avail_q;
        left_d       = left_q;
        right_d      = right_q;
        trans_d      = trans_q;
        mpp_d        = mpp_q;

        if (flush || sos) begin
            // Abort, then a same-cycle request becomes block 0 of the new slice.
            state_d      = nb_req ? StIssue : StIdle;
            blk_x_d      = '0;
            first_line_d = 1'b1;
            err_d        = 1'b0;
            if (flush) begin
                avail_d = 1'b0;
                left_d  = 1'b0;
                right_d = 1'b0;
                trans_d = '0;
                mpp_d   = '0;
            end
        end else begin
            if (nb_req && state_q != StIdle) begin
                err_d = 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (nb_req) begin
                        state_d = StIssue;
                    end
                end
                StIssue: begin
                    state_d = StWait;
                    cnt_d   = CntW'(RD_LATENCY);
                end
                StWait: begin
                    cnt_d = cnt_q - CntW'(1);
                    if (expiry) begin
                        state_d = StLoad;
                        valid_d = 1'b1;
                        avail_d = !first_line_q;
                        left_d  = cur_left;
                        right_d = cur_right;
                        trans_d = pad_trans;
                        mpp_d   = pad_mpp;
                        if (!first_line_q && !decoding_proc_rd_valid) begin
                            err_d = 1'b1;
                        end
                    end else if (decoding_proc_rd_valid) begin
                        err_d = 1'b1;
                    end
                end
                StLoad: begin
                    state_d = StIdle;
                    if (blk_x_q == last_blk) begin
                        blk_x_d      = '0;
                        first_line_d = 1'b0;
                    end else begin
                        blk_x_d = blk_x_q + BlkW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            blk_x_q      <= '0;
            first_line_q <= 1'b1;
            err_q        <= 1'b0;
            valid_q      <= 1'b0;
            avail_q      <= 1'b0;
            left_q       <= 1'b0;
            right_q      <= 1'b0;
            trans_q      <= '0;
            mpp_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            blk_x_q      <= blk_x_d;
            first_line_q <= first_line_d;
            err_q        <= err_d;
            valid_q      <= valid_d;
            avail_q      <= avail_d;
            left_q       <= left_d;
            right_q      <= right_d;
            trans_q      <= trans_d;
            mpp_q        <= mpp_d;
        end
    end

    assign nb_busy               = (state_q != StIdle);
    assign decoding_proc_rd_req  = (state_q == StIssue) && !first_line_q;
    assign nb_valid              = valid_q;
    assign nb_err                = err_q;
    assign above_avail           = avail_q;
    assign left_edge             = left_q;
    assign right_edge            = right_q;
    assign pixelsAboveForTrans_p = trans_q;
    assign pixelsAboveForMpp_p   = mpp_q;

endmodule

// File: tb/tb_above_nbr_ctrl.sv
// Bench for above_nbr_ctrl: directed scenarios with literal expectations plus a random phase
// checked every cycle against a transaction-timeline model.
module tb_above_nbr_ctrl;

    logic              clk = 1'b0;
    logic              rst_n, flush, sos, nb_req, rd_valid;
    logic [11:0]       sw;
    logic [12:0]       mid;
    logic [671:0]      trans_in, trans_p;
    logic [335:0]      mpp_in, mpp_p;
    logic              nb_busy, nb_valid, nb_err, above_avail, left_edge, right_edge, rd_req;

    always #5 clk = ~clk;

    above_nbr_ctrl #(.MAX_SLICE_WIDTH(2560), .RD_LATENCY(4)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .flush                  (flush),
        .sos                    (sos),
        .slice_width            (sw),
        .midPoint               (mid),
        .nb_req                 (nb_req),
        .nb_busy                (nb_busy),
        .nb_valid               (nb_valid),
        .nb_err                 (nb_err),
        .above_avail            (above_avail),
        .left_edge              (left_edge),
        .right_edge             (right_edge),
        .decoding_proc_rd_req   (rd_req),
        .pixelsAboveForTrans_in (trans_in),
        .pixelsAboveForMpp_in   (mpp_in),
        .decoding_proc_rd_valid (rd_valid),
        .pixelsAboveForTrans_p  (trans_p),
        .pixelsAboveForMpp_p    (mpp_p)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int rd_lat = 4;
    int n_rdreq = 0, last_rdreq = -1, n_valid = 0, last_valid = -1;
    bit rand_pix = 1'b1;
    bit rdv_sched[int];

    // Model: at most one live transaction, identified by its acceptance cycle.
    bit           m_active = 1'b0, m_first = 1'b1, m_err = 1'b0;
    int           m_t = 0, m_blk = 0;
    logic [671:0] e_trans = '0;
    logic [335:0] e_mpp = '0;
    logic         e_avail = 1'b0, e_left = 1'b0, e_right = 1'b0;

    task automatic chk_w(input string name, input logic [671:0] act, input logic [671:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_s(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic logic [13:0] tsamp(input int c, input int k);
        return trans_p[(16*c+k)*14 +: 14];
    endfunction

    function automatic logic [13:0] msamp(input int c, input int k);
        return mpp_p[(8*c+k)*14 +: 14];
    endfunction

    task automatic randomize_pix();
        for (int i = 0; i < 48; i++) trans_in[i*14 +: 14] = 14'($urandom());
        for (int i = 0; i < 24; i++) mpp_in[i*14 +: 14] = 14'($urandom());
    endtask

    task automatic set_pattern();
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 16; k++) trans_in[(16*c+k)*14 +: 14] = 14'(100 + k);
            for (int k = 0; k < 8; k++) mpp_in[(8*c+k)*14 +: 14] = 14'(200 + k);
        end
    endtask

    // One clock cycle: inputs already set at posedge+1; compare and advance the model at negedge.
    task automatic tick();
        int d;
        int nb;
        int src;
        logic [13:0] mx;
        rd_valid = rdv_sched.exists(cyc);
        if (rd_valid) rdv_sched.delete(cyc);
        @(negedge clk);
        d = cyc - m_t;
        chk_s("nb_busy", 32'(nb_busy), 32'(m_active));
        chk_s("rd_req", 32'(rd_req), 32'(m_active && d == 1 && !m_first));
        chk_s("nb_valid", 32'(nb_valid), 32'(m_active && d == 6));
        chk_s("nb_err", 32'(nb_err), 32'(m_err));
        chk_s("above_avail", 32'(above_avail), 32'(e_avail));
        chk_s("left_edge", 32'(left_edge), 32'(e_left));
        chk_s("right_edge", 32'(right_edge), 32'(e_right));
        chk_w("trans_p", trans_p, e_trans);
        chk_w("mpp_p", {336'd0, mpp_p}, {336'd0, e_mpp});
        if (rd_req === 1'b1) begin
            n_rdreq++;
            last_rdreq = cyc;
            rdv_sched[cyc + rd_lat] = 1'b1;
        end
        if (nb_valid === 1'b1) begin
            n_valid++;
            last_valid = cyc;
        end
        nb = int'(sw) / 8;
        if (flush || sos) begin
            m_active = 1'b0;
            m_blk    = 0;
            m_first  = 1'b1;
            m_err    = 1'b0;
            if (flush) begin
                e_trans = '0;
                e_mpp   = '0;
                e_avail = 1'b0;
                e_left  = 1'b0;
                e_right = 1'b0;
            end
            if (nb_req) begin
                m_active = 1'b1;
                m_t      = cyc;
            end
        end else if (m_active) begin
            if (nb_req) m_err = 1'b1;
            if (d >= 2 && d <= 4 && rd_valid) m_err = 1'b1;
            if (d == 5) begin
                if (!m_first && !rd_valid) m_err = 1'b1;
                mx = {mid[12], mid};
                for (int c = 0; c < 3; c++) begin
                    for (int k = 0; k < 16; k++) begin
                        src = k;
                        if (m_blk == 0 && k < 4) src = 4;
                        if (m_blk == nb - 1 && k > 11) src = 11;
                        e_trans[(16*c+k)*14 +: 14] =
                            m_first ? mx : trans_in[(16*c+src)*14 +: 14];
                    end
                end
                for (int i = 0; i < 24; i++) e_mpp[i*14 +: 14] = m_first ? mx : mpp_in[i*14 +: 14];
                e_avail = !m_first;
                e_left  = (m_blk == 0);
                e_right = (m_blk == nb - 1);
            end
            if (d == 6) begin
                m_active = 1'b0;
                if (m_blk == nb - 1) begin
                    m_blk   = 0;
                    m_first = 1'b0;
                end else begin
                    m_blk++;
                end
            end
        end else if (nb_req) begin
            m_active = 1'b1;
            m_t      = cyc;
        end
        @(posedge clk);
        cyc++;
        #1;
        nb_req = 1'b0;
        sos    = 1'b0;
        flush  = 1'b0;
        if (rand_pix) randomize_pix();
    endtask

    task automatic run_block(output int lat);
        int t0;
        int nv;
        t0     = cyc;
        nv     = n_valid;
        nb_req = 1'b1;
        tick();
        for (int i = 0; i < 12 && n_valid == nv; i++) tick();
        lat = (n_valid == nv) ? -1 : last_valid - t0;
    endtask

    task automatic new_slice(input int width);
        sw  = 12'(width);
        sos = 1'b1;
        tick();
    endtask

    initial begin
        int lat;
        int t0;
        int nv;
        int nr;
        rst_n = 1'b0; flush = 1'b0; sos = 1'b0; nb_req = 1'b0; rd_valid = 1'b0;
        sw = 12'd32; mid = 13'd2048;
        randomize_pix();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_s("reset_busy", 32'(nb_busy), 32'd0);
        chk_s("reset_valid", 32'(nb_valid), 32'd0);
        chk_s("reset_err", 32'(nb_err), 32'd0);
        chk_w("reset_trans", trans_p, 672'd0);

        // First line of a 4-block slice: midPoint everywhere, no reads.
        new_slice(32);
        for (int b = 0; b < 4; b++) begin
            run_block(lat);
            chk_s("l0_latency", 32'(lat), 32'd6);
            chk_s("l0_avail", 32'(above_avail), 32'd0);
            chk_s("l0_left", 32'(left_edge), 32'(b == 0));
            chk_s("l0_right", 32'(right_edge), 32'(b == 3));
            chk_s("l0_t00", 32'(tsamp(0, 0)), 32'd2048);
            chk_s("l0_t2_15", 32'(tsamp(2, 15)), 32'd2048);
            chk_s("l0_m15", 32'(msamp(1, 5)), 32'd2048);
        end
        chk_s("l0_rdreq_count", 32'(n_rdreq), 32'd0);

        // Second line with a known window.
        rand_pix = 1'b0;
        set_pattern();
        for (int b = 0; b < 4; b++) begin
            nr = n_rdreq;
            t0 = cyc;
            run_block(lat);
            chk_s("l1_latency", 32'(lat), 32'd6);
            chk_s("l1_rdreq_one", 32'(n_rdreq - nr), 32'd1);
            chk_s("l1_rdreq_time", 32'(last_rdreq - t0), 32'd1);
            chk_s("l1_avail", 32'(above_avail), 32'd1);
            chk_s("l1_m13", 32'(msamp(1, 3)), 32'd203);
            if (b == 0) begin
                chk_s("b0_t0", 32'(tsamp(0, 0)), 32'd104);
                chk_s("b0_t3", 32'(tsamp(1, 3)), 32'd104);
                chk_s("b0_t4", 32'(tsamp(2, 4)), 32'd104);
                chk_s("b0_t15", 32'(tsamp(0, 15)), 32'd115);
            end else if (b == 1) begin
                chk_s("b1_t0", 32'(tsamp(1, 0)), 32'd100);
                chk_s("b1_t15", 32'(tsamp(1, 15)), 32'd115);
            end else if (b == 3) begin
                chk_s("b3_t0", 32'(tsamp(2, 0)), 32'd100);
                chk_s("b3_t12", 32'(tsamp(2, 12)), 32'd111);
                chk_s("b3_t15", 32'(tsamp(0, 15)), 32'd111);
            end
        end

        // Single-block slice: both paddings apply.
        new_slice(8);
        run_block(lat);
        run_block(lat);
        chk_s("w8_t0", 32'(tsamp(0, 0)), 32'd104);
        chk_s("w8_t3", 32'(tsamp(2, 3)), 32'd104);
        chk_s("w8_t12", 32'(tsamp(1, 12)), 32'd111);
        chk_s("w8_t15", 32'(tsamp(2, 15)), 32'd111);
        chk_s("w8_left", 32'(left_edge), 32'd1);
        chk_s("w8_right", 32'(right_edge), 32'd1);

        // Request while busy: one transaction only, sticky error until sos.
        nv = n_valid;
        nb_req = 1'b1;
        tick();
        tick();
        tick();
        nb_req = 1'b1;
        tick();
        repeat (10) tick();
        chk_s("busy_req_valids", 32'(n_valid - nv), 32'd1);
        chk_s("busy_req_err", 32'(nb_err), 32'd1);
        new_slice(8);
        chk_s("sos_clears_err", 32'(nb_err), 32'd0);

        // sos during WAIT aborts and restarts at block 0 of a first line.
        new_slice(16);
        run_block(lat);
        run_block(lat);
        run_block(lat);
        chk_s("pre_abort_avail", 32'(above_avail), 32'd1);
        nv = n_valid;
        nb_req = 1'b1;
        tick();
        tick();
        tick();
        sos = 1'b1;
        tick();
        repeat (8) tick();
        chk_s("abort_no_valid", 32'(n_valid - nv), 32'd0);
        run_block(lat);
        chk_s("abort_latency", 32'(lat), 32'd6);
        chk_s("abort_avail", 32'(above_avail), 32'd0);
        chk_s("abort_left", 32'(left_edge), 32'd1);
        chk_s("abort_right", 32'(right_edge), 32'd0);

        // Late rd_valid flags an error but timing is unchanged.
        new_slice(8);
        run_block(lat);
        rd_lat = 5;
        run_block(lat);
        rd_lat = 4;
        chk_s("late_latency", 32'(lat), 32'd6);
        chk_s("late_err", 32'(nb_err), 32'd1);

        // flush clears the held outputs.
        new_slice(8);
        run_block(lat);
        run_block(lat);
        flush = 1'b1;
        tick();
        chk_w("flush_trans", trans_p, 672'd0);
        chk_s("flush_right", 32'(right_edge), 32'd0);

        // Random traffic against the model.
        rand_pix = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                flush = 1'b1;
                sw    = 12'(8 * $urandom_range(1, 8));
            end else if ($urandom_range(0, 299) == 0) begin
                sos = 1'b1;
                sw  = 12'(8 * $urandom_range(1, 8));
            end
            nb_req = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 49) == 0) mid = 13'($urandom());
            rd_lat = ($urandom_range(0, 9) == 0) ? int'($urandom_range(3, 5)) : 4;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/above_nbr_ctrl.md
Name: above_nbr_ctrl

Overview:
- Sits between pixels_buf and the block decoding process. Once per 8x2 block it issues one decoding_proc_rd_req to pixels_buf and captures the returned above-row windows.
- Applies slice-edge padding and first-line substitution, then presents registered, stable above-neighbour sets with a one-cycle valid pulse and availability flags.
- Gives the decoding process a fixed 6-cycle request-to-data latency.

Parameters:
- MAX_SLICE_WIDTH, 2560, maximum slice width in pixels; sets the slice_width port width.
- RD_LATENCY, 4, fixed pixels_buf latency in cycles from decoding_proc_rd_req to decoding_proc_rd_valid.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort; state returns to post-reset
- sos  in  1  start of slice pulse
- slice_width  in  $clog2(MAX_SLICE_WIDTH)  slice width in pixels; multiple of 8, minimum 8
- midPoint  in  13  neutral sample value used when no above line exists
- nb_req  in  1  pulse: neighbours requested for the next block in raster order
- nb_busy  out  1  high from acceptance until nb_valid inclusive
- nb_valid  out  1  one-cycle pulse; output data is updated on this cycle
- nb_err  out  1  sticky: nb_req arrived while busy; cleared by sos or flush
- above_avail  out  1  0 when the block is on the first line of the slice
- left_edge  out  1  block is at blk_x == 0
- right_edge  out  1  block is at blk_x == nblk-1
- decoding_proc_rd_req  out  1  read request to pixels_buf
- pixelsAboveForTrans_in  in  16*3*14  from pixels_buf; component c, position k at bits [(16c+k)*14 +: 14]; k=0 is column x0-4
- pixelsAboveForMpp_in  in  8*3*14  from pixels_buf; position k is column x0+k
- decoding_proc_rd_valid  in  1  from pixels_buf
- pixelsAboveForTrans_p  out  16*3*14  padded transform window, same packing
- pixelsAboveForMpp_p  out  8*3*14  MPP window, same packing

Behaviour:
- Reset and flush values: all outputs 0; blk_x=0; first_line=1; FSM in IDLE. nblk = slice_width>>3, computed combinationally.
- FSM states: IDLE, ISSUE, WAIT, LOAD.
- IDLE -> ISSUE on nb_req (cycle T). nb_busy rises at T+1.
- ISSUE (T+1): decoding_proc_rd_req=1 for exactly one cycle, only if first_line=0. Go to WAIT and load wait counter with RD_LATENCY.
- WAIT: counter decrements each cycle and exits to LOAD when it expires.
  - If first_line=0, decoding_proc_rd_valid must be 1 on the expiry cycle (T+5). Capture the input windows on that cycle.
  - If rd_valid arrives early or late, nb_err is set; data is captured on the expiry cycle regardless.
- LOAD (T+6): outputs are registered and nb_valid=1. above_avail, left_edge and right_edge reflect the current block. Then advance blk_x and return to IDLE; nb_busy falls at T+7.
- A new nb_req accepted at T+7 gives a minimum block period of 7 cycles.
- Padding in LOAD, applied per component:
  - first_line=1: every Trans and MPP sample = midPoint, sign-extended to 14 bits.
  - left_edge: Trans positions 0..3 = Trans position 4.
  - right_edge: Trans positions 12..15 = Trans position 11.
  - nblk==1: both left and right padding apply.
  - MPP samples pass through unmodified when first_line=0.
- blk_x update: increments by 1 per LOAD. At nblk-1 it wraps to 0 and clears first_line; first_line is never set again until sos or flush.
- Outputs hold their value between nb_valid pulses.
- nb_req while busy: ignored (no second transaction); nb_err set.
- sos: blk_x=0, first_line=1, nb_err=0. An in-flight transaction is aborted: no nb_valid, FSM to IDLE, outputs held.
  - sos and nb_req in the same cycle: sos applies first, then the request is accepted as block 0 of the new slice.
- flush: same as sos, and additionally clears all outputs. flush has priority over sos.
- The slice_width change itself is not detected; it must change only when sos or flush is asserted.

Test Plan:
- Reset, slice_width=32, midPoint=2048, sos, then 4 nb_req -> each nb_valid at T+6; zero rd_req issued; all samples 2048; above_avail=0; left_edge on block 0 only, right_edge on block 3 only.
- Second line, pixels_buf model returns Trans position k = 100+k (all components) -> block 0: positions 0..3 = 104, 4..15 = 104..115; block 1: unchanged 100..115; block 3: positions 12..15 = 111; exactly one rd_req per block, at T+1.
- slice_width=8, second line, Trans k = 100+k -> positions 0..3 = 104, 12..15 = 111, both edge flags = 1.
- nb_req at T and T+3 -> single nb_valid at T+6; nb_err=1 until the next sos.
- sos at T+3 during WAIT -> no nb_valid; next nb_req yields above_avail=0, blk_x=0.
- Model delays rd_valid to T+6 -> nb_err=1; nb_valid still at T+6.
